// File: rtl/ifu_inst_queue_pkg.sv
// Shared widths and constants for the IF/ID instruction queue.
// Hold-level decode helper used by the queue top.
package ifu_inst_queue_pkg;

  localparam int INST_DATA_WIDTH = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int HOLD_BUS_WIDTH  = 3;

  localparam logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  // Hold levels from ctrl: none, pc, if, id
  localparam logic [HOLD_BUS_WIDTH-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_BUS_WIDTH-1:0] HOLD_PC   = 3'd1;
  localparam logic [HOLD_BUS_WIDTH-1:0] HOLD_IF   = 3'd2;
  localparam logic [HOLD_BUS_WIDTH-1:0] HOLD_ID   = 3'd3;

  function automatic logic hold_active(input logic [HOLD_BUS_WIDTH-1:0] flag,
                                       input logic [HOLD_BUS_WIDTH-1:0] lvl);
    return (flag >= lvl);
  endfunction

endpackage

// File: rtl/ifu_inst_queue_if.sv
// Fetch-side handshake and decode-side instruction bus of the instruction queue.
// The queue takes the slave modport; the fetch/decode environment takes master.
interface ifu_inst_queue_if;
  import ifu_inst_queue_pkg::*;

  logic                       fetch_valid_i;
  logic                       fetch_ready_o;
  logic [INST_DATA_WIDTH-1:0] fetch_inst_i;
  logic [INST_ADDR_WIDTH-1:0] fetch_addr_i;
  logic [INST_DATA_WIDTH-1:0] inst_o;
  logic [INST_ADDR_WIDTH-1:0] inst_addr_o;
  logic                       inst_valid_o;

  modport slave (
    input  fetch_valid_i, fetch_inst_i, fetch_addr_i,
    output fetch_ready_o, inst_o, inst_addr_o, inst_valid_o
  );

  modport master (
    output fetch_valid_i, fetch_inst_i, fetch_addr_i,
    input  fetch_ready_o, inst_o, inst_addr_o, inst_valid_o
  );

endinterface

// File: rtl/ifu_inst_fifo.sv
// Generic synchronous FIFO: registered storage, combinational head, separate count.
// Push when full and pop when empty are ignored; flush empties in one edge.
module ifu_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage write; contents are don't-care until counted valid, so not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ifu_inst_queue.sv
// Instruction queue plus IF/ID register feeding idu; honours ctrl hold and flush.
// Empty queue bypasses a fetched word straight into the output register.
module ifu_inst_queue
  import ifu_inst_queue_pkg::*;
#(
  parameter int                        DEPTH       = 4,
  parameter logic [HOLD_BUS_WIDTH-1:0] HOLD_LVL_ID = HOLD_ID
) (
  input  logic                      clk,
  input  logic                      rst,
  ifu_inst_queue_if.slave           bus,
  input  logic                      flush_i,
  input  logic [HOLD_BUS_WIDTH-1:0] hold_flag_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int ENTRY_W = INST_DATA_WIDTH + INST_ADDR_WIDTH;

  logic                       hold_s;
  logic                       xfer_s;
  logic                       ready_s;
  logic                       fifo_push_s;
  logic                       fifo_pop_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [ENTRY_W-1:0]         fifo_head_s;
  logic [INST_DATA_WIDTH-1:0] inst_r;
  logic [INST_ADDR_WIDTH-1:0] inst_addr_r;
  logic                       inst_valid_r;

  assign hold_s  = hold_active(hold_flag_i, HOLD_LVL_ID);
  assign ready_s = ~rst & ~fifo_full_s;
  assign xfer_s  = bus.fetch_valid_i & ready_s;

  // Enqueue unless flushed or the word bypasses an empty queue into the output.
  always_comb begin
    fifo_push_s = 1'b0;
    fifo_pop_s  = 1'b0;
    if (flush_i) begin
      fifo_push_s = 1'b0;
      fifo_pop_s  = 1'b0;
    end else if (hold_s) begin
      fifo_push_s = xfer_s;
      fifo_pop_s  = 1'b0;
    end else begin
      fifo_push_s = xfer_s & ~fifo_empty_s;
      fifo_pop_s  = ~fifo_empty_s;
    end
  end

  ifu_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_i),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   ({bus.fetch_inst_i, bus.fetch_addr_i}),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_o)
  );

  // IF/ID register: flush > hold > queue head > bypass > bubble.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      inst_r       <= INST_NOP;
      inst_addr_r  <= INST_ADDR_WIDTH'(0);
      inst_valid_r <= 1'b0;
    end else if (hold_s) begin
      inst_r       <= inst_r;
      inst_addr_r  <= inst_addr_r;
      inst_valid_r <= inst_valid_r;
    end else if (!fifo_empty_s) begin
      inst_r       <= fifo_head_s[ENTRY_W-1:INST_ADDR_WIDTH];
      inst_addr_r  <= fifo_head_s[INST_ADDR_WIDTH-1:0];
      inst_valid_r <= 1'b1;
    end else if (xfer_s) begin
      inst_r       <= bus.fetch_inst_i;
      inst_addr_r  <= bus.fetch_addr_i;
      inst_valid_r <= 1'b1;
    end else begin
      inst_r       <= INST_NOP;
      inst_addr_r  <= inst_addr_r;
      inst_valid_r <= 1'b0;
    end
  end

  assign bus.fetch_ready_o = ready_s;
  assign bus.inst_o        = inst_r;
  assign bus.inst_addr_o   = inst_addr_r;
  assign bus.inst_valid_o  = inst_valid_r;

endmodule
